// File: rtl/counter_ud_mod.sv
// Up/down counter with runtime modulus, programmable step, count enable and
// selectable wrap or saturate behaviour at the bounds.
//
// Legal count range is 0..max_val. wrap and sat are registered one-cycle event
// pulses describing the update just taken. tc is a combinational terminal-count
// flag that follows count and the current direction.
//
// Optional feature (macro WRAP_COUNT_EN): adds a 16-bit saturating counter of
// cycles on which wrap or sat is asserted. The counter is cleared by load_en.
module counter_ud_mod #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              load_en,
  input  logic [WIDTH-1:0]  load,
  input  logic              down,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  max_val,
  input  logic              sat_mode,
  output logic [WIDTH-1:0]  count,
  output logic              wrap,
  output logic              sat,
  output logic              tc
`ifdef WRAP_COUNT_EN
  ,
  output logic [15:0]       wrap_cnt
`endif
);

  // Extended width holds max_val+1 and count+step without overflow.
  localparam int unsigned EW = WIDTH + 1;
  // Comparison width wide enough for both the step and the modulus.
  localparam int unsigned CW = (STEP_W > EW) ? STEP_W : EW;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;

  logic [EW-1:0]    max_ext;
  logic [EW-1:0]    modulus;
  logic [EW-1:0]    cnt_ext;
  logic [CW-1:0]    step_cmp;
  logic [CW-1:0]    mod_cmp;
  logic [EW-1:0]    es;
  logic [EW-1:0]    sum_up;
  logic             in_range;
  logic             up_fits;
  logic             dn_fits;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] up_wrap_val;
  logic [WIDTH-1:0] dn_val;
  logic [WIDTH-1:0] dn_wrap_val;
  logic [WIDTH-1:0] load_clamped;

  // Datapath: effective step, candidate next values and bound checks.
  always_comb begin
    max_ext  = {1'b0, max_val};
    modulus  = max_ext + EW'(1);
    cnt_ext  = {1'b0, count_q};
    step_cmp = CW'(step);
    mod_cmp  = CW'(modulus);
    // A step larger than the modulus is equivalent to exactly one full lap.
    es       = (step_cmp < mod_cmp) ? EW'(step_cmp) : modulus;

    in_range = (count_q <= max_val);

    sum_up      = cnt_ext + es;
    up_fits     = (sum_up <= max_ext);
    up_val      = sum_up[WIDTH-1:0];
    up_wrap_val = WIDTH'(sum_up - modulus);

    dn_fits     = (es <= cnt_ext);
    dn_val      = WIDTH'(cnt_ext - es);
    // count < es <= modulus here, so the result lies in 0..max_val.
    dn_wrap_val = WIDTH'(cnt_ext + (modulus - es));

    load_clamped = (load > max_val) ? max_val : load;
  end

  // Next-state selection: load beats enable, enable beats hold.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    if (load_en) begin
      count_d = load_clamped;
    end else if (en) begin
      if (!in_range) begin
        // max_val was lowered below the count: restart silently from zero.
        count_d = '0;
      end else if (!down) begin
        if (up_fits) begin
          count_d = up_val;
        end else if (sat_mode) begin
          count_d = max_val;
          sat_d   = 1'b1;
        end else begin
          count_d = up_wrap_val;
          wrap_d  = 1'b1;
        end
      end else begin
        if (dn_fits) begin
          count_d = dn_val;
        end else if (sat_mode) begin
          count_d = '0;
          sat_d   = 1'b1;
        end else begin
          count_d = dn_wrap_val;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign sat   = sat_q;
  assign tc    = (!down && (count_q == max_val)) || (down && (count_q == '0));

`ifdef WRAP_COUNT_EN
  logic [15:0] wrap_cnt_q;

  // Saturating tally of registered wrap/sat pulses; load_en clears it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wrap_cnt_q <= '0;
    end else if (load_en) begin
      wrap_cnt_q <= '0;
    end else if ((wrap_q || sat_q) && (wrap_cnt_q != 16'hFFFF)) begin
      wrap_cnt_q <= wrap_cnt_q + 16'd1;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_counter_ud_mod.sv
// Self-checking bench for counter_ud_mod: a table of directed vectors with
// hand-computed expectations, a free-running binary-counter sequence, and
// (when WRAP_COUNT_EN is defined) a wrap_cnt sequence.
module tb_counter_ud_mod;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       load_en;
  logic [7:0] load;
  logic       down;
  logic [3:0] step;
  logic [7:0] max_val;
  logic       sat_mode;
  logic [7:0] count;
  logic       wrap;
  logic       sat;
  logic       tc;
`ifdef WRAP_COUNT_EN
  logic [15:0] wrap_cnt;
`endif

  int n_vec;
  int n_bad;

  typedef struct {
    logic       rstn;
    logic       en;
    logic       load_en;
    logic [7:0] load;
    logic       down;
    logic [3:0] step;
    logic [7:0] max_val;
    logic       sat_mode;
    logic [7:0] e_count;
    logic       e_wrap;
    logic       e_sat;
    logic       e_tc;
  } vec_t;

  vec_t vecs[$];

  counter_ud_mod #(
    .WIDTH  (8),
    .STEP_W (4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .load_en  (load_en),
    .load     (load),
    .down     (down),
    .step     (step),
    .max_val  (max_val),
    .sat_mode (sat_mode),
    .count    (count),
    .wrap     (wrap),
    .sat      (sat),
    .tc       (tc)
`ifdef WRAP_COUNT_EN
    ,
    .wrap_cnt (wrap_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic v(input logic r, input logic e, input logic le, input logic [7:0] ld,
                   input logic dn, input logic [3:0] st, input logic [7:0] mx,
                   input logic sm, input logic [7:0] ec, input logic ew, input logic es,
                   input logic et);
    vec_t x;
    x.rstn = r;   x.en = e;     x.load_en = le; x.load = ld;
    x.down = dn;  x.step = st;  x.max_val = mx; x.sat_mode = sm;
    x.e_count = ec; x.e_wrap = ew; x.e_sat = es; x.e_tc = et;
    vecs.push_back(x);
  endtask

  // Drive one vector, take one clock edge, check outputs 1 time unit later.
  task automatic apply(input vec_t x, input string tag, input int idx);
    rstn = x.rstn;  en = x.en;     load_en = x.load_en; load = x.load;
    down = x.down;  step = x.step; max_val = x.max_val; sat_mode = x.sat_mode;
    @(posedge clk);
    #1;
    n_vec++;
    if (count !== x.e_count || wrap !== x.e_wrap || sat !== x.e_sat || tc !== x.e_tc) begin
      n_bad++;
      $display("FAIL %s[%0d]: got count=%h wrap=%b sat=%b tc=%b, want count=%h wrap=%b sat=%b tc=%b",
               tag, idx, count, wrap, sat, tc, x.e_count, x.e_wrap, x.e_sat, x.e_tc);
    end
  endtask

  initial begin
    vec_t x;
    n_vec = 0;
    n_bad = 0;
    rstn = 1'b0; en = 1'b1; load_en = 1'b0; load = '0;
    down = 1'b0; step = 4'd1; max_val = 8'd9; sat_mode = 1'b0;

    //  rstn en le load   dn step mx     sm  count  w  s  tc
    // Reset held for 3 cycles with en=1, then count 0..9 and wrap to 0.
    for (int i = 0; i < 3; i++) v(0, 1, 0, 8'h00, 0, 1, 8'd9, 0, 8'd0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) v(1, 1, 0, 8'h00, 0, 1, 8'd9, 0, 8'(i), 0, 0, (i == 9));
    v(1, 1, 0, 8'h00, 0, 1, 8'd9, 0, 8'd0, 1, 0, 0);
    // Step 4 modulo 10 from 0: 4, 8, 2 (wrap), 6, 0 (wrap).
    v(1, 1, 0, 8'h00, 0, 4, 8'd9, 0, 8'd4, 0, 0, 0);
    v(1, 1, 0, 8'h00, 0, 4, 8'd9, 0, 8'd8, 0, 0, 0);
    v(1, 1, 0, 8'h00, 0, 4, 8'd9, 0, 8'd2, 1, 0, 0);
    v(1, 1, 0, 8'h00, 0, 4, 8'd9, 0, 8'd6, 0, 0, 0);
    v(1, 1, 0, 8'h00, 0, 4, 8'd9, 0, 8'd0, 1, 0, 0);
    // Hold.
    v(1, 0, 0, 8'h00, 0, 4, 8'd9, 0, 8'd0, 0, 0, 0);
    // Saturate down by 3 from load 5: 5, 2, 0 (sat), 0 (sat again).
    v(1, 1, 1, 8'd5,  1, 3, 8'd9, 1, 8'd5, 0, 0, 0);
    v(1, 1, 0, 8'h00, 1, 3, 8'd9, 1, 8'd2, 0, 0, 0);
    v(1, 1, 0, 8'h00, 1, 3, 8'd9, 1, 8'd0, 0, 1, 1);
    v(1, 1, 0, 8'h00, 1, 3, 8'd9, 1, 8'd0, 0, 1, 1);
    // Step 0: no movement, no pulse.
    v(1, 1, 0, 8'h00, 1, 0, 8'd9, 1, 8'd0, 0, 0, 1);
    // Load clamps to max_val; lowering max_val below count restarts at 0.
    v(1, 1, 1, 8'hC8, 0, 1, 8'h64, 0, 8'h64, 0, 0, 1);
    v(1, 1, 0, 8'h00, 0, 1, 8'h10, 0, 8'h00, 0, 0, 0);
    // Reset beats a simultaneous load.
    v(1, 1, 1, 8'd7,  0, 1, 8'd9, 0, 8'd7, 0, 0, 0);
    v(0, 1, 1, 8'd3,  0, 1, 8'd9, 0, 8'd0, 0, 0, 0);
    // Load with en=0; step 15 clamps to 10, a full lap: 3 -> 3 with wrap.
    v(1, 0, 1, 8'd3,  0, 15, 8'd9, 0, 8'd3, 0, 0, 0);
    v(1, 1, 0, 8'h00, 0, 15, 8'd9, 0, 8'd3, 1, 0, 0);
    // Down wrap: 3 - 5 mod 10 = 8.
    v(1, 1, 0, 8'h00, 1, 5, 8'd9, 0, 8'd8, 1, 0, 0);
    // Saturate up: 8 + 4 clamps to 9, and again at the bound.
    v(1, 1, 1, 8'd8,  0, 4, 8'd9, 1, 8'd8, 0, 0, 0);
    v(1, 1, 0, 8'h00, 0, 4, 8'd9, 1, 8'd9, 0, 1, 1);
    v(1, 1, 0, 8'h00, 0, 4, 8'd9, 1, 8'd9, 0, 1, 1);
    // max_val=0: out-of-range restart, then every nonzero step pulses.
    v(1, 1, 0, 8'h00, 0, 5, 8'd0, 1, 8'd0, 0, 0, 1);
    v(1, 1, 0, 8'h00, 0, 5, 8'd0, 1, 8'd0, 0, 1, 1);
    v(1, 1, 0, 8'h00, 0, 5, 8'd0, 0, 8'd0, 1, 0, 1);
    v(1, 1, 0, 8'h00, 1, 1, 8'd0, 0, 8'd0, 1, 0, 1);
    // Full-range binary behaviour at the 8-bit edges.
    v(1, 1, 1, 8'hFF, 0, 1, 8'hFF, 0, 8'hFF, 0, 0, 1);
    v(1, 1, 0, 8'h00, 0, 1, 8'hFF, 0, 8'h00, 1, 0, 0);
    v(1, 1, 0, 8'h00, 1, 1, 8'hFF, 0, 8'hFF, 1, 0, 0);
    // Out-of-range count holds while disabled, restarts when enabled.
    v(1, 1, 1, 8'h50, 0, 1, 8'hFF, 0, 8'h50, 0, 0, 0);
    v(1, 0, 0, 8'h00, 0, 1, 8'h20, 0, 8'h50, 0, 0, 0);
    v(1, 1, 0, 8'h00, 0, 1, 8'h20, 0, 8'h00, 0, 0, 0);

    foreach (vecs[i]) apply(vecs[i], "table", i);

    // Free-running full-range up counter across two rollovers.
    x.rstn = 1; x.en = 1; x.load_en = 1; x.load = 8'h00; x.down = 0;
    x.step = 4'd1; x.max_val = 8'hFF; x.sat_mode = 0;
    x.e_count = 8'h00; x.e_wrap = 0; x.e_sat = 0; x.e_tc = 0;
    apply(x, "binary", 0);
    x.load_en = 0;
    for (int i = 1; i <= 520; i++) begin
      x.e_count = 8'(i % 256);
      x.e_wrap  = ((i % 256) == 0);
      x.e_tc    = ((i % 256) == 255);
      apply(x, "binary", i);
    end

`ifdef WRAP_COUNT_EN
    // max_val=1, step 1: 10 updates wrap 5 times; the last pulse is
    // tallied one cycle later.
    x.load_en = 1; x.load = 8'h00; x.max_val = 8'd1; x.e_count = 8'd0;
    x.e_wrap = 0; x.e_tc = 0;
    apply(x, "wcnt_load", 0);
    x.load_en = 0;
    for (int i = 1; i <= 10; i++) begin
      x.e_count = 8'(i % 2);
      x.e_wrap  = ((i % 2) == 0);
      x.e_tc    = ((i % 2) == 1);
      apply(x, "wcnt_run", i);
    end
    x.en = 0; x.e_wrap = 0;
    apply(x, "wcnt_hold", 0);
    n_vec++;
    if (wrap_cnt !== 16'd5) begin
      n_bad++;
      $display("FAIL wrap_cnt_after_run: got %0d, want 5", wrap_cnt);
    end
    x.load_en = 1; x.load = 8'd1; x.e_count = 8'd1; x.e_tc = 1;
    apply(x, "wcnt_clear", 0);
    n_vec++;
    if (wrap_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL wrap_cnt_clear: got %0d, want 0", wrap_cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
